qspi_mem_target: RTL

// - Quad-SPI responder (target end of the QSPI bus the CPU drives as initiator) that exposes a byte memory port.
// - Lets an external QSPI host or a bench model load and read back program/data memory over 4 data lines.
// - Oversampled design: one system clock; SPI pins are sampled, never used as clocks.

---
 rtl/qspi_pkg.sv | 22 ++
 rtl/spi_pin_sync.sv | 48 ++++
 rtl/qspi_mem_target.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI memory target.
package qspi_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_ADDR    = 3'd2,
        S_DUMMY   = 3'd3,
        S_RD_DATA = 3'd4,
        S_WR_DATA = 3'd5,
        S_IGNORE  = 3'd6
    } qspi_state_e;

    localparam logic [7:0] CMD_READ_DEFAULT  = 8'hEB;
    localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h38;
    localparam int         NIBBLES_PER_BYTE  = 2;

    function automatic logic [7:0] shift_nibble(input logic [7:0] cur, input logic [3:0] nib);
        return {cur[3:0], nib};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for sclk, cs_n and IO[3:0] with sclk edge and cs_n fall detection.
module spi_pin_sync (
    input  logic       clock,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [3:0] data,
    output logic       sclk_rise_s,
    output logic       sclk_fall_s,
    output logic       cs_n_s,
    output logic       cs_fall_s,
    output logic [3:0] data_s
);

    logic       sclk_m_r, sclk_s_r, sclk_q_r;
    logic       cs_m_r, cs_s_r, cs_q_r;
    logic [3:0] data_m_r, data_s_r;

    // Synchronizer chains plus one history flop each for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_m_r <= 1'b0;
            sclk_s_r <= 1'b0;
            sclk_q_r <= 1'b0;
            cs_m_r   <= 1'b1;
            cs_s_r   <= 1'b1;
            cs_q_r   <= 1'b1;
            data_m_r <= 4'h0;
            data_s_r <= 4'h0;
        end else begin
            sclk_m_r <= sclk;
            sclk_s_r <= sclk_m_r;
            sclk_q_r <= sclk_s_r;
            cs_m_r   <= cs_n;
            cs_s_r   <= cs_m_r;
            cs_q_r   <= cs_s_r;
            data_m_r <= data;
            data_s_r <= data_m_r;
        end
    end

    assign sclk_rise_s = sclk_s_r & ~sclk_q_r;
    assign sclk_fall_s = ~sclk_s_r & sclk_q_r;
    assign cs_n_s      = cs_s_r;
    assign cs_fall_s   = ~cs_s_r & cs_q_r;
    assign data_s      = data_s_r;

endmodule

// File: rtl/qspi_mem_target.sv
// Quad-SPI responder bridging host read/write commands onto a byte-wide memory port.
module qspi_mem_target
    import qspi_pkg::*;
#(
    parameter int         DATA_BUS_WIDTH = 8,
    parameter int         ADDRESS_WIDTH  = 16,
    parameter int         DUMMY_CYCLES   = 4,
    parameter logic [7:0] CMD_READ       = CMD_READ_DEFAULT,
    parameter logic [7:0] CMD_WRITE      = CMD_WRITE_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      spi_clk_in,
    input  logic                      spi_cs_n_in,
    input  logic [3:0]                spi_data_in,
    output logic [3:0]                spi_data_out,
    output logic [3:0]                spi_data_oe,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
    output logic                      busy,
    output logic                      cmd_error
);

    localparam logic [7:0] ADDR_LAST  = 8'(ADDRESS_WIDTH / 4 - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES);
    localparam logic [7:0] BYTE_LAST  = 8'(NIBBLES_PER_BYTE - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    logic       sclk_rise_s, sclk_fall_s, cs_n_s, cs_fall_s;
    logic [3:0] data_s;
    logic [7:0] cmd_byte_s;
    logic       rd_state_s;

    qspi_state_e state_r, state_n;
    logic [7:0]                cnt_r, cnt_n;
    logic [3:0]                cmd_hi_r, cmd_hi_n;
    logic                      is_read_r, is_read_n;
    logic [ADDRESS_WIDTH-1:0]  addr_r, addr_n;
    logic [DATA_BUS_WIDTH-1:0] wdata_r, wdata_n;
    logic [DATA_BUS_WIDTH-1:0] rd_r, rd_n;
    logic                      we_r, we_n, re_r, re_n, re_d_r;
    logic                      err_r, err_n, busy_r, busy_n;
    logic [3:0]                out_r, out_n, out_c, oe_r, oe_n;

    spi_pin_sync u_sync (
        .clock       (clock),
        .reset       (reset),
        .sclk        (spi_clk_in),
        .cs_n        (spi_cs_n_in),
        .data        (spi_data_in),
        .sclk_rise_s (sclk_rise_s),
        .sclk_fall_s (sclk_fall_s),
        .cs_n_s      (cs_n_s),
        .cs_fall_s   (cs_fall_s),
        .data_s      (data_s)
    );

    assign cmd_byte_s = {cmd_hi_r, data_s};

    // State, counter and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= 8'd0;
            cmd_hi_r  <= 4'h0;
            is_read_r <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            rd_r      <= '0;
            we_r      <= 1'b0;
            re_r      <= 1'b0;
            re_d_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            out_r     <= 4'h0;
            oe_r      <= 4'h0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            cmd_hi_r  <= cmd_hi_n;
            is_read_r <= is_read_n;
            addr_r    <= addr_n;
            wdata_r   <= wdata_n;
            rd_r      <= rd_n;
            we_r      <= we_n;
            re_r      <= re_n;
            re_d_r    <= re_r;
            err_r     <= err_n;
            busy_r    <= busy_n;
            out_r     <= out_n;
            oe_r      <= oe_n;
        end
    end

    // Next-state and datapath decode; a deasserted CS overrides every state
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        cmd_hi_n  = cmd_hi_r;
        is_read_n = is_read_r;
        addr_n    = we_r ? (addr_r + ADDR_ONE) : addr_r;
        wdata_n   = wdata_r;
        rd_n      = re_d_r ? mem_rdata : rd_r;
        out_c     = out_r;
        we_n      = 1'b0;
        re_n      = 1'b0;
        err_n     = 1'b0;
        if ((state_r != S_IDLE) && cs_n_s) begin
            state_n = S_IDLE;
            cnt_n   = 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cs_fall_s) begin
                        state_n = S_CMD;
                        cnt_n   = 8'd0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_CMD: begin
                    if (sclk_rise_s && (cnt_r == BYTE_LAST)) begin
                        cnt_n = 8'd0;
                        if (cmd_byte_s == CMD_READ) begin
                            state_n   = S_ADDR;
                            is_read_n = 1'b1;
                        end else if (cmd_byte_s == CMD_WRITE) begin
                            state_n   = S_ADDR;
                            is_read_n = 1'b0;
                        end else begin
                            state_n = S_IGNORE;
                            err_n   = 1'b1;
                        end
                    end else if (sclk_rise_s) begin
                        cmd_hi_n = data_s;
                        cnt_n    = cnt_r + 8'd1;
                    end else begin
                        cnt_n = cnt_r;
                    end
                end
                S_ADDR: begin
                    if (sclk_rise_s) begin
                        addr_n = {addr_r[ADDRESS_WIDTH-5:0], data_s};
                        if (cnt_r == ADDR_LAST) begin
                            cnt_n = 8'd0;
                            if (is_read_r) begin
                                state_n = S_DUMMY;
                                re_n    = 1'b1;
                            end else begin
                                state_n = S_WR_DATA;
                            end
                        end else begin
                            cnt_n = cnt_r + 8'd1;
                        end
                    end else begin
                        cnt_n = cnt_r;
                    end
                end
                S_DUMMY: begin
                    if (sclk_rise_s && (cnt_r != DUMMY_LAST)) begin
                        cnt_n = cnt_r + 8'd1;
                    end else if (sclk_fall_s && (cnt_r == DUMMY_LAST)) begin
                        state_n = S_RD_DATA;
                        out_c   = rd_r[7:4];
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt_r;
                    end
                end
                S_RD_DATA: begin
                    // Prefetch the next byte while its low nibble is still on the bus
                    if (sclk_fall_s && !cnt_r[0]) begin
                        out_c  = rd_r[3:0];
                        addr_n = addr_r + ADDR_ONE;
                        re_n   = 1'b1;
                        cnt_n  = 8'd1;
                    end else if (sclk_fall_s) begin
                        out_c = rd_r[7:4];
                        cnt_n = 8'd0;
                    end else begin
                        cnt_n = cnt_r;
                    end
                end
                S_WR_DATA: begin
                    if (sclk_rise_s) begin
                        wdata_n = shift_nibble(wdata_r, data_s);
                        if (cnt_r == BYTE_LAST) begin
                            we_n  = 1'b1;
                            cnt_n = 8'd0;
                        end else begin
                            cnt_n = cnt_r + 8'd1;
                        end
                    end else begin
                        cnt_n = cnt_r;
                    end
                end
                S_IGNORE: begin
                    state_n = S_IGNORE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
        rd_state_s = (state_n == S_RD_DATA);
        oe_n       = rd_state_s ? 4'hF : 4'h0;
        out_n      = rd_state_s ? out_c : 4'h0;
        busy_n     = (state_n != S_IDLE);
    end

    assign spi_data_out = out_r;
    assign spi_data_oe  = oe_r;
    assign mem_addr     = addr_r;
    assign mem_wdata    = wdata_r;
    assign mem_we       = we_r;
    assign mem_re       = re_r;
    assign busy         = busy_r;
    assign cmd_error    = err_r;

endmodule
